// File: rtl/accel_spi_responder.sv
// ADXL345-style SPI mode-3 responder with oversampled pins, coherent sample snapshot and config regs.
// Optional DATA_READY interrupt on int1 when ACCEL_RESP_INT_EN is defined.
module accel_spi_responder #(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        int1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
  logic sclk_q, csn_q;
  logic sclk_s, csn_s, sdi_s;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '1;
      csn_sync  <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b1;
      csn_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sclk_q    <= sclk_s;
      csn_q     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  // SCLK edges only count while chip select is asserted.
  assign sclk_rise = sclk_s & ~sclk_q & ~csn_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~csn_s;
  assign csn_fall  = csn_q & ~csn_s;
  assign csn_rise  = ~csn_q & csn_s;
  assign busy      = ~csn_s;

  // Sample path: holding regs, pending sample while busy, frozen snapshot per transaction.
  logic [47:0] hold, pend, snap, hold_d;
  logic        pend_valid;
  logic        direct_load, pend_load, hold_load;

  assign direct_load = sample_valid & (csn_s | csn_fall);
  assign pend_load   = csn_rise & pend_valid & ~sample_valid;
  assign hold_load   = direct_load | pend_load;
  assign hold_d      = direct_load ? {sample_z, sample_y, sample_x} : pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      snap       <= '0;
    end else begin
      if (hold_load) hold <= hold_d;
      if (sample_valid && !csn_s && !csn_fall) begin
        pend       <= {sample_z, sample_y, sample_x};
        pend_valid <= 1'b1;
      end else if (hold_load) begin
        pend_valid <= 1'b0;
      end
      if (csn_fall) snap <= hold_d & {48{direct_load}} | hold & {48{~direct_load}};
    end
  end

  // Transaction state and register map.
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh;
  logic       rnw, mb;
  logic [5:0] addr;
  logic [7:0] cfg [6];
  logic       cfg_hit, snap_hit;
  logic [2:0] cfg_idx, snap_idx;
  logic [7:0] rd_byte;
  logic [7:0] rx_byte;

  assign cfg_hit  = (addr >= 6'h2C) && (addr <= 6'h31);
  assign snap_hit = (addr >= 6'h32) && (addr <= 6'h37);
  // 0x2C..0x31 and 0x32..0x37 map to 0..5 using only the low address bits.
  assign cfg_idx  = addr[2:0] - 3'd4;
  assign snap_idx = addr[2:0] - 3'd2;
  assign rx_byte  = {rx_sh, sdi_s};

  always_comb begin
    rd_byte = 8'h00;
    if (addr == 6'h00)  rd_byte = DEVID;
    else if (cfg_hit)   rd_byte = cfg[cfg_idx];
    else if (snap_hit)  rd_byte = snap[{snap_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '1;
      rnw        <= 1'b0;
      mb         <= 1'b0;
      addr       <= '0;
      spi_sdo    <= 1'b1;
      spi_sdo_oe <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      for (int i = 0; i < 6; i++) cfg[i] <= 8'h00;
      cfg[0]     <= 8'h0A;
    end else begin
      wr_strobe <= 1'b0;
      if (csn_s) begin
        // Covers the CSN-rise clock: any partial byte is dropped here.
        state      <= IDLE;
        bit_cnt    <= '0;
        spi_sdo    <= 1'b1;
        spi_sdo_oe <= 1'b0;
      end else if (csn_fall) begin
        state   <= CMD;
        bit_cnt <= '0;
      end else begin
        case (state)
          CMD: begin
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[5:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rnw   <= rx_sh[6];
                mb    <= rx_sh[5];
                addr  <= {rx_sh[4:0], sdi_s};
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_fall && rnw) begin
              spi_sdo_oe <= 1'b1;
              if (bit_cnt == 3'd0) begin
                spi_sdo <= rd_byte[7];
                tx_sh   <= {rd_byte[6:0], 1'b1};
              end else begin
                spi_sdo <= tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b1};
              end
            end
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[5:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rnw) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= rx_byte;
                  if (cfg_hit) cfg[cfg_idx] <= rx_byte;
                end
                if (mb) addr <= addr + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ACCEL_RESP_INT_EN
  logic int1_q, int_clr_pend, rd_at_32;

  assign rd_at_32 = (state == DATA) && rnw && sclk_fall && (bit_cnt == 3'd0) && (addr == 6'h32);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int1_q       <= 1'b0;
      int_clr_pend <= 1'b0;
    end else begin
      if (csn_fall)      int_clr_pend <= 1'b0;
      else if (rd_at_32) int_clr_pend <= 1'b1;
      // A new sample beats a clear landing in the same clock.
      if (hold_load && cfg[2][7])        int1_q <= 1'b1;
      else if (csn_rise && int_clr_pend) int1_q <= 1'b0;
    end
  end

  assign int1 = int1_q;
`else
  assign int1 = 1'b0;
`endif

endmodule

// File: tb/tb_accel_spi_responder.sv
// Self-checking bench for accel_spi_responder: SPI mode-3 initiator model with expected-value queues.
module tb_accel_spi_responder;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        spi_clk = 1'b1;
  logic        spi_csn = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, int1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [13:0] wr_exp_q[$];
  logic [13:0] wr_obs_q[$];

  accel_spi_responder dut (
    .clk          (clk),
    .reset        (reset),
    .spi_clk      (spi_clk),
    .spi_csn      (spi_csn),
    .spi_sdi      (spi_sdi),
    .spi_sdo      (spi_sdo),
    .spi_sdo_oe   (spi_sdo_oe),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .int1         (int1)
  );

  always #5 clk = ~clk;

  // Every high clock of wr_strobe is an observed write; a long pulse shows up as extras.
  always @(negedge clk) if (wr_strobe) wr_obs_q.push_back({wr_addr, wr_data});

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic cs_begin();
    @(posedge clk);
    #2;
    spi_csn = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    spi_csn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk = 1'b0;
      spi_sdi = tx[i];
      #HALF;
      spi_clk = 1'b1;
      rx[i] = spi_sdo;
      oe_all = oe_all & spi_sdo_oe;
      oe_any = oe_any | spi_sdo_oe;
      #HALF;
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(posedge clk);
    #2;
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(posedge clk);
    #2;
    sample_valid = 1'b0;
  endtask

  // Reads n bytes after cmd into rx_q; optionally strobes a new X sample after byte sv_after.
  task automatic spi_read(input logic [7:0] cmd, input int n, input int sv_after);
    logic [7:0] rx;
    logic a, b;
    cs_begin();
    spi_bits(cmd, 8, rx, a, b);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, rx, a, b);
      rx_q.push_back(rx);
      if (k == sv_after) pulse_sample(16'h7FFF, 16'hFF38, 16'h0100);
    end
    cs_end();
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    logic a, b;
    cs_begin();
    spi_bits(cmd, 8, rx, a, b);
    spi_bits(data, 8, rx, a, b);
    cs_end();
  endtask

  task automatic test_reset();
    #22;
    checks += 7;
    if (spi_sdo !== 1'b1)    begin failures++; $display("FAIL reset_sdo got=%b exp=1", spi_sdo); end
    if (spi_sdo_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_sdo_oe); end
    if (wr_strobe !== 1'b0)  begin failures++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
    if (wr_addr !== 6'h00)   begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    if (wr_data !== 8'h00)   begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (int1 !== 1'b0)       begin failures++; $display("FAIL reset_int1 got=%b exp=0", int1); end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_devid();
    logic [7:0] rx;
    logic oe_all, oe_any;
    cs_begin();
    spi_bits(8'h80, 8, rx, oe_all, oe_any);
    checks += 2;
    if (oe_any !== 1'b0) begin failures++; $display("FAIL devid_cmd_oe got=%b exp=0", oe_any); end
    if (busy !== 1'b1)   begin failures++; $display("FAIL devid_busy got=%b exp=1", busy); end
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    checks += 2;
    if (rx !== 8'hE5)     begin failures++; $display("FAIL devid_data got=%h exp=e5", rx); end
    if (oe_all !== 1'b1)  begin failures++; $display("FAIL devid_data_oe got=%b exp=1", oe_all); end
    cs_end();
    checks += 3;
    if (spi_sdo_oe !== 1'b0) begin failures++; $display("FAIL devid_end_oe got=%b exp=0", spi_sdo_oe); end
    if (spi_sdo !== 1'b1)    begin failures++; $display("FAIL devid_end_sdo got=%b exp=1", spi_sdo); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL devid_end_busy got=%b exp=0", busy); end
    // Holding registers start at zero.
    exp_q = '{8'h00, 8'h00};
    spi_read(8'hF2, 2, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL reset_sample_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_samples();
    pulse_sample(16'h0123, 16'hFF38, 16'h0100);
    repeat (4) @(posedge clk);
    #2;
    exp_q = '{8'h23, 8'h01, 8'h38, 8'hFF, 8'h00, 8'h01};
    spi_read(8'hF2, 6, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL sample_burst got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_coherent();
    exp_q = '{8'h23, 8'h01, 8'h38, 8'hFF, 8'h00, 8'h01};
    spi_read(8'hF2, 6, 0);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL coherent_burst got=%h exp=%h", g, e); end
    end
    exp_q = '{8'hFF, 8'h7F};
    spi_read(8'hF2, 2, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL pending_sample got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_write();
    wr_exp_q.push_back({6'h2D, 8'h08});
    spi_write(8'h2D, 8'h08);
    wr_exp_q.push_back({6'h10, 8'h55});
    spi_write(8'h10, 8'h55);
    checks++;
    if (wr_obs_q.size() !== wr_exp_q.size()) begin
      failures++;
      $display("FAIL write_strobe_count got=%0d exp=%0d", wr_obs_q.size(), wr_exp_q.size());
    end
    while (wr_exp_q.size() > 0) begin
      logic [13:0] e, g;
      e = wr_exp_q.pop_front();
      g = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 14'hxxxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL write_strobe got=%h exp=%h", g, e); end
    end
    wr_obs_q.delete();
    exp_q = '{8'h08, 8'h0A, 8'h00};
    spi_read(8'hAD, 1, -1);
    spi_read(8'hAC, 1, -1);
    spi_read(8'h90, 1, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL write_readback got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    logic a, b;
    cs_begin();
    spi_bits(8'h31, 8, rx, a, b);
    spi_bits(8'hFF, 5, rx, a, b);
    cs_end();
    checks += 3;
    if (wr_obs_q.size() != 0) begin
      failures++;
      $display("FAIL partial_no_strobe got=%0d exp=0", wr_obs_q.size());
    end
    if (spi_sdo_oe !== 1'b0) begin failures++; $display("FAIL partial_oe got=%b exp=0", spi_sdo_oe); end
    if (spi_sdo !== 1'b1)    begin failures++; $display("FAIL partial_sdo got=%b exp=1", spi_sdo); end
    wr_obs_q.delete();
    exp_q = '{8'h00};
    spi_read(8'hB1, 1, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL partial_readback got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_addr_step();
    exp_q = '{8'h00, 8'hE5, 8'hE5, 8'hE5};
    spi_read(8'hFF, 2, -1);
    spi_read(8'h80, 2, -1);
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin failures++; $display("FAIL addr_step got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_int();
`ifdef ACCEL_RESP_INT_EN
    logic [7:0] rx;
    logic a, b;
    spi_write(8'h2E, 8'h80);
    wr_obs_q.delete();
    pulse_sample(16'h0001, 16'h0002, 16'h0003);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (int1 !== 1'b1) begin failures++; $display("FAIL int_set got=%b exp=1", int1); end
    cs_begin();
    spi_bits(8'hB2, 8, rx, a, b);
    spi_bits(8'h00, 8, rx, a, b);
    checks += 2;
    if (rx !== 8'h01)  begin failures++; $display("FAIL int_read got=%h exp=01", rx); end
    if (int1 !== 1'b1) begin failures++; $display("FAIL int_hold_until_csn got=%b exp=1", int1); end
    cs_end();
    checks++;
    if (int1 !== 1'b0) begin failures++; $display("FAIL int_clear got=%b exp=0", int1); end
`else
    spi_write(8'h2E, 8'h80);
    wr_obs_q.delete();
    pulse_sample(16'h0001, 16'h0002, 16'h0003);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (int1 !== 1'b0) begin failures++; $display("FAIL int_disabled got=%b exp=0", int1); end
`endif
  endtask

  initial begin
    test_reset();
    test_devid();
    test_samples();
    test_coherent();
    test_write();
    test_partial();
    test_addr_step();
    test_int();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
